// File: rtl/alien_swarm_ctrl.sv
// Alien formation controller: alive/armed state, shared-origin march, edge descent, hits, waves.
// Optional macro ALIEN_SPEEDUP_EN shortens the step period as aliens are destroyed.
module alien_swarm_ctrl #(
    parameter int unsigned NUM_ROWS      = 4,
    parameter int unsigned NUM_COLUMNS   = 8,
    parameter int unsigned SCALING       = 2,
    parameter int unsigned ALIEN_W       = 11,
    parameter int unsigned ALIEN_H       = 8,
    parameter int unsigned SPACING_X     = 40,
    parameter int unsigned SPACING_Y     = 40,
    parameter int unsigned INITIAL_X     = 50,
    parameter int unsigned INITIAL_Y     = 50,
    parameter int unsigned MAX_X         = 640,
    parameter int unsigned FLOOR_Y       = 400,
    parameter int unsigned STEP_X        = 4,
    parameter int unsigned STEP_Y        = 16,
    parameter int unsigned BASE_PERIOD   = 48,
    parameter int unsigned MIN_PERIOD    = 2,
    parameter int unsigned LEVEL_SPEEDUP = 4,
    localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int unsigned CW = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
    localparam int unsigned NW = $clog2(NUM_ROWS * NUM_COLUMNS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            frame_tick,
    input  logic                            start_level,
    input  logic [15:0]                     scan_x,
    input  logic [15:0]                     scan_y,
    input  logic                            hit_valid,
    input  logic [RW-1:0]                   hit_row,
    input  logic [CW-1:0]                   hit_col,
    output logic                            hit_ack,
    output logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix,
    output logic [NUM_ROWS*NUM_COLUMNS-1:0] armed_matrix,
    output logic [15:0]                     origin_x,
    output logic [15:0]                     origin_y,
    output logic                            direction,
    output logic [NW-1:0]                   alive_count,
    output logic [3:0]                      level,
    output logic                            wave_cleared,
    output logic                            invaded,
    output logic                            alien_pixel
);

    localparam int unsigned NumCells = NUM_ROWS * NUM_COLUMNS;
    localparam int unsigned IW       = (NumCells > 1) ? $clog2(NumCells) : 1;
    localparam int unsigned SpriteW  = ALIEN_W * SCALING;
    localparam int unsigned SpriteH  = ALIEN_H * SCALING;

    typedef enum logic [1:0] {StIdle, StMarch, StCleared, StInvaded} state_e;

    state_e              state_q, state_d;
    logic [NumCells-1:0] alive_q, alive_d;
    logic [15:0]         origin_x_q, origin_x_d;
    logic [15:0]         origin_y_q, origin_y_d;
    logic                dir_q, dir_d;
    logic [NW-1:0]       count_q, count_d;
    logic [3:0]          level_q, level_d;
    logic [15:0]         step_cnt_q, step_cnt_d;
    logic                hit_ack_q, hit_ack_d;

    logic [NUM_COLUMNS-1:0] col_live;
    logic [NUM_ROWS-1:0]    row_live;
    int                     lc, rc, lr;
    logic                   right_exit, left_exit, at_edge, floor_reached;
    logic [31:0]            lvl_red, lvl_raw, lvl_p;
    logic [15:0]            period;
    logic                   step_fire;
    logic                   hit_in_range, hit_live;
    int unsigned            hit_cell;
    logic [IW-1:0]          hit_idx;

    // Extreme live columns/row, taken from the pre-hit matrix.
    always_comb begin
        col_live = '0;
        row_live = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                if (alive_q[r*NUM_COLUMNS+c]) begin
                    col_live[c] = 1'b1;
                    row_live[r] = 1'b1;
                end
            end
        end
        lc = 0;
        rc = 0;
        lr = 0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            if (col_live[NUM_COLUMNS-1-c]) lc = NUM_COLUMNS - 1 - c;
            if (col_live[c]) rc = c;
        end
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_live[r]) lr = r;
        end
    end

    always_comb begin
        right_exit = (int'(origin_x_q) + rc * int'(SPACING_X) + int'(SpriteW) + int'(STEP_X))
                     > int'(MAX_X);
        left_exit  = (int'(origin_x_q) + lc * int'(SPACING_X)) < int'(STEP_X);
        at_edge    = dir_q ? right_exit : left_exit;
        floor_reached = (int'(origin_y_q) + int'(STEP_Y) + lr * int'(SPACING_Y) + int'(SpriteH))
                        >= int'(FLOOR_Y);
    end

    always_comb begin
        lvl_red = 32'(level_q) * LEVEL_SPEEDUP;
        lvl_raw = (BASE_PERIOD > lvl_red) ? BASE_PERIOD - lvl_red : 32'd0;
        lvl_p   = (lvl_raw > MIN_PERIOD) ? lvl_raw : MIN_PERIOD;
`ifdef ALIEN_SPEEDUP_EN
        begin
            logic [31:0] killed, sp_raw;
            killed = NumCells - 32'(count_q);
            sp_raw = (lvl_p > (killed >> 2)) ? lvl_p - (killed >> 2) : 32'd0;
            period = 16'((sp_raw > MIN_PERIOD) ? sp_raw : MIN_PERIOD);
        end
`else
        period = 16'(lvl_p);
`endif
        // Compare with >= so a period shrinking under the counter still fires.
        step_fire = (32'(step_cnt_q) + 32'd1) >= 32'(period);
    end

    always_comb begin
        hit_in_range = (32'(hit_row) < NUM_ROWS) && (32'(hit_col) < NUM_COLUMNS);
        hit_cell     = 32'(hit_row) * NUM_COLUMNS + 32'(hit_col);
        hit_idx      = IW'(hit_cell);
        hit_live     = hit_valid && (state_q != StIdle) && hit_in_range && alive_q[hit_idx];
    end

    always_comb begin
        state_d    = state_q;
        alive_d    = alive_q;
        origin_x_d = origin_x_q;
        origin_y_d = origin_y_q;
        dir_d      = dir_q;
        count_d    = count_q;
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        hit_ack_d  = 1'b0;

        if (hit_live) begin
            alive_d[hit_idx] = 1'b0;
            count_d          = count_q - NW'(1);
            hit_ack_d        = 1'b1;
        end

        unique case (state_q)
            StIdle, StCleared: begin
                if (start_level) begin
                    state_d    = StMarch;
                    alive_d    = '1;
                    count_d    = NW'(NumCells);
                    origin_x_d = 16'(INITIAL_X);
                    origin_y_d = 16'(INITIAL_Y);
                    dir_d      = 1'b1;
                    step_cnt_d = '0;
                    if (state_q == StCleared && level_q != 4'd15) level_d = level_q + 4'd1;
                end
            end
            StMarch: begin
                if (hit_live && count_q == NW'(1)) begin
                    state_d = StCleared;
                end else if (frame_tick) begin
                    if (step_fire) begin
                        step_cnt_d = '0;
                        if (at_edge) begin
                            origin_y_d = origin_y_q + 16'(STEP_Y);
                            dir_d      = ~dir_q;
                            if (floor_reached) state_d = StInvaded;
                        end else begin
                            origin_x_d = dir_q ? origin_x_q + 16'(STEP_X)
                                               : origin_x_q - 16'(STEP_X);
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 16'd1;
                    end
                end
            end
            StInvaded: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            alive_q    <= '0;
            origin_x_q <= 16'(INITIAL_X);
            origin_y_q <= 16'(INITIAL_Y);
            dir_q      <= 1'b1;
            count_q    <= '0;
            level_q    <= '0;
            step_cnt_q <= '0;
            hit_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= alive_d;
            origin_x_q <= origin_x_d;
            origin_y_q <= origin_y_d;
            dir_q      <= dir_d;
            count_q    <= count_d;
            level_q    <= level_d;
            step_cnt_q <= step_cnt_d;
            hit_ack_q  <= hit_ack_d;
        end
    end

    // An alien is armed when nothing alive sits below it in its column.
    always_comb begin
        armed_matrix = '0;
        for (int c = 0; c < NUM_COLUMNS; c++) begin
            logic below;
            below = 1'b0;
            for (int r = NUM_ROWS - 1; r >= 0; r--) begin
                armed_matrix[r*NUM_COLUMNS+c] = alive_q[r*NUM_COLUMNS+c] && !below;
                below = below | alive_q[r*NUM_COLUMNS+c];
            end
        end
    end

    always_comb begin
        alien_pixel = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLUMNS; c++) begin
                int dx, dy;
                dx = int'(scan_x) - int'(origin_x_q) - c * int'(SPACING_X);
                dy = int'(scan_y) - int'(origin_y_q) - r * int'(SPACING_Y);
                if (alive_q[r*NUM_COLUMNS+c] && dx >= 0 && dx < int'(SpriteW) &&
                    dy >= 0 && dy < int'(SpriteH)) begin
                    alien_pixel = 1'b1;
                end
            end
        end
    end

    assign hit_ack      = hit_ack_q;
    assign alive_matrix = alive_q;
    assign origin_x     = origin_x_q;
    assign origin_y     = origin_y_q;
    assign direction    = dir_q;
    assign alive_count  = count_q;
    assign level        = level_q;
    assign wave_cleared = (state_q == StCleared);
    assign invaded      = (state_q == StInvaded);

endmodule
